// File: rtl/arbitro_rr_param_pkg.sv
// Shared definitions for the transaction-layer arbiter: FSM encoding, init code,
// arbitration mode constants and a constant-foldable clog2.
package pcie_tl_pkg;

    typedef logic [1:0] fsm_t;

    localparam fsm_t ST_INIT  = 2'd0;
    localparam fsm_t ST_ARB   = 2'd1;
    localparam fsm_t ST_STALL = 2'd2;

    localparam logic [3:0] INIT_CODE_DEF = 4'b0001;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arbitro_rr_param_if.sv
// Bus between the arbiter and its FIFO/controller environment.
// stall_cnt exists only when ARB_STALL_STATS_EN is defined.
interface arbitro_rr_param_if #(
    parameter int NUM_CH = 4
);
    import pcie_tl_pkg::*;

    localparam int IDX_W = clog2(NUM_CH);

    logic [3:0]          state;
    logic [NUM_CH-1:0]   almost_full;
    logic [NUM_CH-1:0]   empty_orange;
    logic [NUM_CH-1:0]   empty_purple;
    logic [NUM_CH-1:0]   pop;
    logic                push;
    logic [IDX_W-1:0]    push_ch;
    logic [2*NUM_CH-1:0] empties;
`ifdef ARB_STALL_STATS_EN
    logic [15:0]         stall_cnt;

    modport slave  (input  state, almost_full, empty_orange, empty_purple,
                    output pop, push, push_ch, empties, stall_cnt);
    modport master (output state, almost_full, empty_orange, empty_purple,
                    input  pop, push, push_ch, empties, stall_cnt);
`else
    modport slave  (input  state, almost_full, empty_orange, empty_purple,
                    output pop, push, push_ch, empties);
    modport master (output state, almost_full, empty_orange, empty_purple,
                    input  pop, push, push_ch, empties);
`endif

endinterface

// File: rtl/arbitro_rr_param_rr_select.sv
// Rotating-priority finder: first set request at or above start_i, wrapping
// modulo N. Start index 0 degenerates to fixed lowest-index priority.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the farthest offset down so the nearest hit wins last.
    always_comb begin
        int          pos;
        logic        hit;
        logic [IDX_W-1:0] best;
        logic        any;
        best = '0;
        any  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start_i) + k;
            pos = (pos >= N) ? pos - N : pos;
            hit  = req_i[IDX_W'(pos)];
            best = hit ? IDX_W'(pos) : best;
            any  = any | hit;
        end
        idx_o   = best;
        valid_o = any;
        grant_o = any ? ({{(N-1){1'b0}}, 1'b1} << best) : '0;
    end

endmodule

// File: rtl/arbitro_rr_param.sv
// Parametrised orange-FIFO arbiter: fixed-priority or burst round-robin pop,
// registered push toward destinations. Optional stall statistics: ARB_STALL_STATS_EN.
module arbitro_rr_param
    import pcie_tl_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         MODE      = 1,
    parameter int         BURST     = 4,
    parameter logic [3:0] INIT_CODE = INIT_CODE_DEF
) (
    input logic              clk,
    input logic              reset_L,
    arbitro_rr_param_if.slave bus
);

    localparam int IDX_W = clog2(NUM_CH);

    fsm_t             fsm_q, fsm_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cnt_inc_s;
    logic             push_q;
    logic [IDX_W-1:0] push_ch_q;

    logic             init_s;
    logic             bp_s;
    logic             pop_en_s;
    logic [NUM_CH-1:0] req_s;
    logic [NUM_CH-1:0] sel_gnt_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic [IDX_W-1:0] start_s;
    logic             sel_valid_s;

    assign init_s  = (bus.state == INIT_CODE);
    assign bp_s    = |bus.almost_full;
    assign req_s   = ~bus.empty_orange;
    assign start_s = (MODE == MODE_RR) ? cur_q : '0;

    rr_select #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i   (req_s),
        .start_i (start_s),
        .grant_o (sel_gnt_s),
        .idx_o   (sel_idx_s),
        .valid_o (sel_valid_s)
    );

    // Init and backpressure gate the grant combinationally so no pop leaks.
    assign pop_en_s     = !init_s && !bp_s && sel_valid_s;
    assign bus.pop      = pop_en_s ? sel_gnt_s : '0;
    assign bus.empties  = init_s ? '0 : {bus.empty_purple, bus.empty_orange};
    assign bus.push     = push_q;
    assign bus.push_ch  = push_ch_q;

    // Controller FSM next state
    always_comb begin
        fsm_d = fsm_q;
        if (init_s) begin
            fsm_d = ST_INIT;
        end else begin
            case (fsm_q)
                ST_INIT:  fsm_d = ST_ARB;
                ST_ARB:   fsm_d = bp_s ? ST_STALL : ST_ARB;
                ST_STALL: fsm_d = bp_s ? ST_STALL : ST_ARB;
                default:  fsm_d = ST_INIT;
            endcase
        end
    end

    // Burst bookkeeping: a switch of channel restarts the count at 1.
    always_comb begin
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        cnt_inc_s = (sel_idx_s == cur_q) ? (cnt_q + 4'd1) : 4'd1;
        if (init_s) begin
            cur_d = '0;
            cnt_d = 4'd0;
        end else if (pop_en_s && (MODE == MODE_RR)) begin
            if (cnt_inc_s == 4'(BURST)) begin
                cur_d = (sel_idx_s == IDX_W'(NUM_CH - 1)) ? '0 : (sel_idx_s + IDX_W'(1));
                cnt_d = 4'd0;
            end else begin
                cur_d = sel_idx_s;
                cnt_d = cnt_inc_s;
            end
        end else begin
            cur_d = cur_q;
            cnt_d = cnt_q;
        end
    end

    // State, burst and push registers; push mirrors the one-cycle FIFO read latency.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            fsm_q     <= ST_INIT;
            cur_q     <= '0;
            cnt_q     <= 4'd0;
            push_q    <= 1'b0;
            push_ch_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cur_q  <= cur_d;
            cnt_q  <= cnt_d;
            push_q <= pop_en_s;
            if (pop_en_s) begin
                push_ch_q <= sel_idx_s;
            end else begin
                push_ch_q <= push_ch_q;
            end
        end
    end

`ifdef ARB_STALL_STATS_EN
    logic [15:0] stall_q;
    logic        stall_ev_s;

    assign stall_ev_s    = !init_s && bp_s && (|req_s);
    assign bus.stall_cnt = stall_q;

    // Saturating count of cycles where traffic was ready but blocked downstream.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stall_q <= 16'd0;
        end else if (init_s) begin
            stall_q <= 16'd0;
        end else if (stall_ev_s && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end else begin
            stall_q <= stall_q;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Directed bench for arbitro_rr_param: fixed priority, burst round-robin,
// backpressure, early empty, NUM_CH=3 wrap and a random onehot0 sweep.
module tb_arbitro_rr_param;

    localparam logic [3:0] ST_INIT_C = 4'b0001;
    localparam logic [3:0] ST_RUN_C  = 4'b0010;

    typedef struct packed {
        logic       v;
        logic [1:0] ch;
    } exp_t;

    logic       clk;
    logic       reset_L;
    logic [3:0] st, af, eo, ep;
    int         dsel;
    int         n_cmp;
    int         n_err;
    exp_t       sbq[$];

    logic [3:0]  obs_pop;
    logic        obs_push;
    logic [1:0]  obs_push_ch;
    logic [7:0]  obs_empties;

    arbitro_rr_param_if #(.NUM_CH(4)) if_a ();
    arbitro_rr_param_if #(.NUM_CH(4)) if_b ();
    arbitro_rr_param_if #(.NUM_CH(3)) if_c ();

    arbitro_rr_param #(.NUM_CH(4), .MODE(0), .BURST(4), .INIT_CODE(4'b0001)) dut_a (
        .clk(clk), .reset_L(reset_L), .bus(if_a.slave));
    arbitro_rr_param #(.NUM_CH(4), .MODE(1), .BURST(4), .INIT_CODE(4'b0001)) dut_b (
        .clk(clk), .reset_L(reset_L), .bus(if_b.slave));
    arbitro_rr_param #(.NUM_CH(3), .MODE(1), .BURST(1), .INIT_CODE(4'b0001)) dut_c (
        .clk(clk), .reset_L(reset_L), .bus(if_c.slave));

    assign if_a.state = st;  assign if_a.almost_full = af;
    assign if_a.empty_orange = eo;  assign if_a.empty_purple = ep;
    assign if_b.state = st;  assign if_b.almost_full = af;
    assign if_b.empty_orange = eo;  assign if_b.empty_purple = ep;
    assign if_c.state = st;  assign if_c.almost_full = af[2:0];
    assign if_c.empty_orange = eo[2:0];  assign if_c.empty_purple = ep[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (dsel)
            0: begin
                obs_pop = if_a.pop; obs_push = if_a.push;
                obs_push_ch = if_a.push_ch; obs_empties = if_a.empties;
            end
            1: begin
                obs_pop = if_b.pop; obs_push = if_b.push;
                obs_push_ch = if_b.push_ch; obs_empties = if_b.empties;
            end
            default: begin
                obs_pop = {1'b0, if_c.pop}; obs_push = if_c.push;
                obs_push_ch = if_c.push_ch; obs_empties = {2'b00, if_c.empties};
            end
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] v);
        oh2idx = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) oh2idx = 2'(i);
    endfunction

    // One cycle: inputs already set at a negedge; check pop, empties and the push
    // owed by the previous cycle, then queue this cycle's expected push.
    task automatic cyc(input logic [3:0] exp_pop, input string tag);
        exp_t e;
        #1;
        chk({tag, ".pop"}, 16'(obs_pop), 16'(exp_pop));
        if (dsel != 2)
            chk({tag, ".empties"}, 16'(obs_empties), (st == ST_INIT_C) ? 16'd0 : 16'({ep, eo}));
        e = sbq.pop_front();
        chk({tag, ".push"}, 16'(obs_push), 16'(e.v));
        if (e.v) chk({tag, ".push_ch"}, 16'(obs_push_ch), 16'(e.ch));
        sbq.push_back({(exp_pop != 4'd0), oh2idx(exp_pop)});
        @(negedge clk);
    endtask

    task automatic select(input int d);
        st = ST_INIT_C;
        af = 4'd0;
        repeat (2) @(negedge clk);
        dsel = d;
        sbq.delete();
        sbq.push_back('0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; dsel = 0;
        reset_L = 1'b0; st = ST_INIT_C; af = 4'd0; eo = 4'd0; ep = 4'd0;
        sbq.push_back('0);
        #1;
        chk("reset.pop", 16'(obs_pop), 16'd0);
        chk("reset.push", 16'(obs_push), 16'd0);
        chk("reset.empties", 16'(obs_empties), 16'd0);
        @(negedge clk);
        reset_L = 1'b1;

        // Fixed priority (dut_a)
        cyc(4'b0000, "init");
        st = ST_RUN_C;
        cyc(4'b0001, "leave_init");
        eo = 4'b1010; ep = 4'b0110;
        cyc(4'b0001, "fp0");
        cyc(4'b0001, "fp1");
        eo = 4'b1011;
        cyc(4'b0100, "fp_ch0_empty");
        cyc(4'b0100, "fp_ch0_empty2");
        eo = 4'b1111;
        cyc(4'b0000, "fp_all_empty");
        eo = 4'b0000;
        cyc(4'b0001, "fp_refill");
        st = ST_INIT_C;
        cyc(4'b0000, "fp_init_mid");

        // Round-robin bursts (dut_b)
        select(1);
        st = ST_RUN_C; eo = 4'd0; ep = 4'd0;
        for (int k = 0; k < 18; k++) cyc(4'b0001 << ((k / 4) % 4), "rr_burst");

        // Backpressure mid-burst of ch1
        select(1);
        st = ST_RUN_C;
        for (int k = 0; k < 4; k++) cyc(4'b0001, "bp_ch0");
        cyc(4'b0010, "bp_ch1a");
        cyc(4'b0010, "bp_ch1b");
        af = 4'b0100;
        for (int k = 0; k < 3; k++) cyc(4'b0000, "bp_stall");
        af = 4'b0000;
`ifdef ARB_STALL_STATS_EN
        chk("stall_cnt", if_b.stall_cnt, 16'd3);
`endif
        cyc(4'b0010, "bp_ch1c");
        cyc(4'b0010, "bp_ch1d");
        cyc(4'b0100, "bp_ch2");

        // Early empty of ch1 after one pop
        select(1);
        st = ST_RUN_C;
        for (int k = 0; k < 4; k++) cyc(4'b0001, "ee_ch0");
        cyc(4'b0010, "ee_ch1");
        eo = 4'b0010;
        for (int k = 0; k < 4; k++) cyc(4'b0100, "ee_ch2");
        cyc(4'b1000, "ee_ch3");
        eo = 4'b0000;

        // NUM_CH = 3, BURST = 1 rotation (dut_c)
        select(2);
        st = ST_RUN_C;
        for (int k = 0; k < 7; k++) cyc(4'b0001 << (k % 3), "rot3");

        // Random traffic on dut_c: grant is onehot0 and respects all gates
        for (int k = 0; k < 60; k++) begin
            eo = 4'($urandom_range(0, 7));
            af = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, 2)) : 4'd0;
            st = ($urandom_range(0, 9) == 0) ? ST_INIT_C : ST_RUN_C;
            #1;
            chk("rand.onehot0", 16'($onehot0(if_c.pop)), 16'd1);
            chk("rand.nonempty", 16'(if_c.pop & eo[2:0]), 16'd0);
            chk("rand.gated", ((st == ST_INIT_C) || (af != 4'd0)) ? 16'(if_c.pop) : 16'd0, 16'd0);
            chk("rand.liveness", ((st != ST_INIT_C) && (af == 4'd0) && (eo[2:0] != 3'b111))
                                 ? 16'(|if_c.pop) : 16'd1, 16'd1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_param.md
Name: arbitro_rr_param

Overview:
- Parametrised successor of the transaction-layer FIFO arbiter.
- Selects one of NUM_CH orange source FIFOs per cycle and pops it, subject to destination backpressure.
- Generates a registered push toward the destination FIFOs, aligned to source FIFO read latency.
- Supports fixed-priority or weighted round-robin (burst) arbitration, and forwards the empty vectors to the control FSM.

Parameters:
- NUM_CH, 4, number of channels (orange sources, purple sources and destinations each); 2..8.
- MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin with bursts.
- BURST, 4, maximum consecutive pops granted to one channel in MODE 1; 1..15.
- INIT_CODE, 4'b0001, encoding of the controller INIT state.

Ports:
- clk  in  1  system clock, all flops on rising edge.
- reset_L  in  1  asynchronous active-low reset.
- state  in  4  controller state; equal to INIT_CODE means init.
- almost_full  in  NUM_CH  destination FIFO almost-full flags.
- empty_orange  in  NUM_CH  orange source FIFO empty flags.
- empty_purple  in  NUM_CH  purple source FIFO empty flags.
- pop  out  NUM_CH  one-hot-or-zero pop to orange sources (combinational).
- push  out  1  destination push, registered.
- push_ch  out  clog2(NUM_CH)  channel index that produced the current push, registered.
- empties  out  2*NUM_CH  {empty_purple, empty_orange}, combinational.

Behaviour:
- Reset: reset_L = 0 asynchronously clears push, push_ch, cur, cnt and the FSM (to INIT).
  - pop = 0 and empties = 0 while the FSM is in INIT.
- FSM states are INIT, ARB and STALL; the state register updates each clk.
  - INIT -> ARB when state != INIT_CODE.
  - Any state -> INIT when state == INIT_CODE. This takes effect on pop combinationally in the same cycle.
  - ARB -> STALL when |almost_full; STALL -> ARB when all almost_full are 0.
  - Backpressure also gates pop combinationally, with no one-cycle leak.
- Pop is asserted only when all of the following hold: state != INIT_CODE, no almost_full, selected channel non-empty.
  - At most one pop bit is ever high.
- Channel selection:
  - MODE 0: lowest-index channel with empty_orange = 0.
  - MODE 1: first non-empty channel scanning upward from cur, wrapping modulo NUM_CH.
- Burst bookkeeping (MODE 1), on each pop of channel sel:
  - If sel == cur: cnt <= cnt + 1; otherwise cur <= sel and cnt <= 1.
  - When the resulting count equals BURST: cur <= (sel + 1) mod NUM_CH and cnt <= 0.
- Burst boundary conditions:
  - cur channel goes empty mid-burst: the scan moves on the same cycle to the next non-empty channel; cnt restarts at 1 on that pop.
  - Stall mid-burst: cur and cnt hold, and the burst resumes after the stall.
  - All sources empty: pop = 0, cur and cnt hold.
- Push: push <= |pop and push_ch <= index(pop), i.e. one cycle latency (synchronous FIFO read).
  - push_ch holds its last value when push = 0.
- Init entered mid-operation:
  - A pop issued in the cycle before init still produces its push.
  - Next edge: cur <= 0, cnt <= 0.
- Widths: cnt is 4 bits. cur wraps explicitly modulo NUM_CH, including non-power-of-2 values.

Optional Feature:
- ARB_STALL_STATS_EN.
  - Defined: adds output stall_cnt (16 bits), a saturating count of cycles with state != INIT_CODE, |almost_full, and any empty_orange = 0. It saturates at 16'hFFFF and clears on reset or in INIT.
  - Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pcie_tl_pkg holds:
  - FSM state encoding (INIT, ARB, STALL);
  - INIT_CODE default;
  - MODE_FIXED / MODE_RR constants;
  - the clog2 helper function.
- One sub-module, rr_select: combinational rotate-priority finder.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and index.
  - Reused for MODE 0 with start index = 0.

Test Plan:
- Reset and init: reset_L = 0, then state = 4'b0001 with all sources non-empty -> pop = 0, push = 0, empties = 0. After state = 4'b0010: pop = 4'b0001 the same cycle and push = 1 on the next edge.
- Fixed priority (MODE 0): empty_orange = 4'b1010 -> pop = 4'b0001 each cycle. Make channel 0 empty (4'b1011) -> pop = 4'b0100.
- Round-robin bursts (MODE 1, BURST = 4, all non-empty) -> pop sequence ch0 x4, ch1 x4, ch2 x4, ch3 x4, ch0 ...; push_ch follows one cycle later.
- Backpressure: almost_full[2] = 1 for 3 cycles in the middle of the ch1 burst (after 2 pops) -> pop = 0 for exactly 3 cycles, then 2 more ch1 pops before moving to ch2. With ARB_STALL_STATS_EN, stall_cnt = 3.
- Early empty: ch1 empties after 1 pop of its burst -> the next pop is ch2 in the same cycle; no idle cycle and no double grant.
- NUM_CH = 3, MODE 1, BURST = 1, all non-empty -> pop rotates 0, 1, 2, 0 with correct wrap; a random-traffic check confirms pop is always onehot0.
